// File: rtl/br_defs_pkg.sv
// Shared opcode definitions for the branch pipeline.
package br_defs_pkg;
   localparam logic [7:0] OP_JIRL = 8'h13;
   localparam logic [7:0] OP_B    = 8'h14;
   localparam logic [7:0] OP_BL   = 8'h15;
   localparam logic [7:0] OP_BEQ  = 8'h16;
   localparam logic [7:0] OP_BNE  = 8'h17;
   localparam logic [7:0] OP_BLT  = 8'h18;
   localparam logic [7:0] OP_BGE  = 8'h19;
   localparam logic [7:0] OP_BLTU = 8'h1A;
   localparam logic [7:0] OP_BGEU = 8'h1B;
endpackage

// File: rtl/br_pkg.sv
// Branch-resolution helpers: branch-kind classification and immediate sign extension.
package br_pkg;
   import br_defs_pkg::*;

   typedef enum logic [1:0] {JUMP, COND_S, COND_U, INVALID} br_kind_e;

   // Word offset, sign-extended to 64 bits; callers truncate to their PC width.
   function automatic logic [63:0] sext_off(input logic [25:0] imm, input logic wide);
      if (wide) return {{36{imm[25]}}, imm, 2'b00};
      else      return {{46{imm[15]}}, imm[15:0], 2'b00};
   endfunction

   // Equality compares are sign-agnostic, so they share the unsigned class.
   function automatic br_kind_e kind_of(input logic [7:0] op);
      case (op)
         OP_JIRL, OP_B, OP_BL:            return JUMP;
         OP_BLT, OP_BGE:                  return COND_S;
         OP_BEQ, OP_BNE, OP_BLTU, OP_BGEU: return COND_U;
         default:                         return INVALID;
      endcase
   endfunction
endpackage

// File: rtl/br_resolve_unit_if.sv
// Request/result bundle between the issue stage and the branch resolve unit.
// Counter signals exist only when BR_STATS_EN is defined.
interface br_resolve_unit_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        op;
   logic [ADDR_W-1:0] rj;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] pc;
   logic [25:0]       offset;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              out_valid;
   logic              out_ready;
   logic              taken;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] link_addr;
   logic              mispredict;
   logic [ADDR_W-1:0] redirect_pc;
`ifdef BR_STATS_EN
   logic [CNT_W-1:0]  cnt_branch;
   logic [CNT_W-1:0]  cnt_mispredict;
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   modport master (
      output flush, in_valid, op, rj, rd, pc, offset, pred_taken, pred_target, out_ready,
      input  in_ready, out_valid, taken, target, link_addr, mispredict, redirect_pc
`ifdef BR_STATS_EN
      , input cnt_branch, cnt_mispredict
`endif
   );

   modport slave (
      input  flush, in_valid, op, rj, rd, pc, offset, pred_taken, pred_target, out_ready,
      output in_ready, out_valid, taken, target, link_addr, mispredict, redirect_pc
`ifdef BR_STATS_EN
      , output cnt_branch, cnt_mispredict
`endif
   );
endinterface

// File: rtl/br_eval.sv
// Combinational branch evaluation: target, direction, link address and misprediction.
module br_eval
   import br_pkg::*;
   import br_defs_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [7:0]        op_i,
   input  logic [ADDR_W-1:0] rj_i,
   input  logic [ADDR_W-1:0] rd_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [25:0]       offset_i,
   input  logic              pred_taken_i,
   input  logic [ADDR_W-1:0] pred_target_i,
   output logic              taken_o,
   output logic [ADDR_W-1:0] target_o,
   output logic [ADDR_W-1:0] link_addr_o,
   output logic              mispredict_o,
   output logic [ADDR_W-1:0] redirect_pc_o
);
   br_kind_e          kind;
   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] base;
   logic              eq, lt_s, lt_u;

   always_comb begin
      kind        = kind_of(op_i);
      off         = ADDR_W'(sext_off(offset_i, (op_i == OP_B) || (op_i == OP_BL)));
      base        = (op_i == OP_JIRL) ? rj_i : pc_i;
      target_o    = base + off;
      link_addr_o = pc_i + ADDR_W'(4);
      eq          = (rj_i == rd_i);
      lt_s        = ($signed(rj_i) < $signed(rd_i));
      lt_u        = (rj_i < rd_i);

      case (kind)
         JUMP:    taken_o = 1'b1;
         COND_S:  taken_o = (op_i == OP_BLT) ? lt_s : !lt_s;
         COND_U: begin
            case (op_i)
               OP_BEQ:  taken_o = eq;
               OP_BNE:  taken_o = !eq;
               OP_BLTU: taken_o = lt_u;
               default: taken_o = !lt_u;
            endcase
         end
         default: taken_o = 1'b0;
      endcase

      mispredict_o  = (taken_o != pred_taken_i) ||
                      (taken_o && pred_taken_i && (target_o != pred_target_i));
      redirect_pc_o = taken_o ? target_o : link_addr_o;
   end
endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: one-cycle registered result with valid/ready handshake and flush.
// Define BR_STATS_EN to add saturating branch / mispredict counters.
module br_resolve_unit #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic clk,
   input  logic reset,
   br_resolve_unit_if.slave io
);
   typedef struct packed {
      logic              taken;
      logic              mispredict;
      logic [ADDR_W-1:0] target;
      logic [ADDR_W-1:0] link_addr;
      logic [ADDR_W-1:0] redirect_pc;
   } res_t;

   if (ADDR_W < 28 || ADDR_W > 64) begin : g_bad_addr_w
      $error("ADDR_W must be in 28..64");
   end

   logic              e_taken, e_mispredict;
   logic [ADDR_W-1:0] e_target, e_link, e_redirect;
   res_t              res_d, res_q;
   logic              valid_d, valid_q;
   logic              accept, consume;

   br_eval #(.ADDR_W(ADDR_W)) u_eval (
      .op_i          (io.op),
      .rj_i          (io.rj),
      .rd_i          (io.rd),
      .pc_i          (io.pc),
      .offset_i      (io.offset),
      .pred_taken_i  (io.pred_taken),
      .pred_target_i (io.pred_target),
      .taken_o       (e_taken),
      .target_o      (e_target),
      .link_addr_o   (e_link),
      .mispredict_o  (e_mispredict),
      .redirect_pc_o (e_redirect)
   );

   assign io.in_ready = !valid_q || io.out_ready;
   assign accept      = io.in_valid && io.in_ready && !io.flush;
   assign consume     = valid_q && io.out_ready;

   // Flush wins over a same-cycle accept; accept wins over a plain consume (no bubble).
   always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      if (io.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         res_d   = '{taken: e_taken, mispredict: e_mispredict, target: e_target,
                     link_addr: e_link, redirect_pc: e_redirect};
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         res_q   <= '0;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
      end
   end

   assign io.out_valid   = valid_q;
   assign io.taken       = res_q.taken;
   assign io.mispredict  = res_q.mispredict;
   assign io.target      = res_q.target;
   assign io.link_addr   = res_q.link_addr;
   assign io.redirect_pc = res_q.redirect_pc;

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] cnt_br_d, cnt_br_q, cnt_mp_d, cnt_mp_q;
   logic             cnt_evt;

   // A result discarded by flush is never counted.
   assign cnt_evt = consume && !io.flush;

   always_comb begin
      cnt_br_d = cnt_br_q;
      cnt_mp_d = cnt_mp_q;
      if (cnt_evt && !(&cnt_br_q)) cnt_br_d = cnt_br_q + CNT_W'(1);
      if (cnt_evt && res_q.mispredict && !(&cnt_mp_q)) cnt_mp_d = cnt_mp_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_br_q <= '0;
         cnt_mp_q <= '0;
      end else begin
         cnt_br_q <= cnt_br_d;
         cnt_mp_q <= cnt_mp_d;
      end
   end

   assign io.cnt_branch     = cnt_br_q;
   assign io.cnt_mispredict = cnt_mp_q;
`endif
endmodule
